// File: rtl/sysid_ext_slave_if.sv
// Avalon-MM slave bus bundle for the system-identification block.
// Master drives address/strobes/write data; slave returns pipelined read data.
interface sysid_ext_slave_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_ext_slave.sv
// System-identification slave: ID/timestamp/scratch/uptime/caps/user words with
// a fixed-latency read pipeline and coherent 64-bit uptime snapshot.
module sysid_ext_slave #(
  parameter logic [31:0] SYSTEM_ID      = 32'h1111_1111,
  parameter logic [31:0] TIMESTAMP      = 32'h52FE_6E76,
  parameter logic [31:0] SCRATCH_RESET  = 32'h0000_0000,
  parameter int          ADDR_W         = 4,
  parameter int          NUM_USER_WORDS = 2,
  parameter logic [32*((NUM_USER_WORDS > 0) ? NUM_USER_WORDS : 1)-1:0] USER_WORDS = '0,
  parameter int          UPTIME_W       = 48,
  parameter int          READ_LATENCY   = 1
) (
  input logic              clock,
  input logic              reset,
  sysid_ext_slave_if.slave bus
);

  if ((NUM_USER_WORDS < 0) || (NUM_USER_WORDS > 8) || ((6 + NUM_USER_WORDS) > (2 ** ADDR_W)) ||
      (UPTIME_W < 33) || (UPTIME_W > 64) || (READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_param_error
    $error("sysid_ext_slave: illegal parameter combination");
  end

  logic [UPTIME_W-1:0]     uptime_r;
  logic [31:0]             scratch_r;
  logic [31:0]             hi_snap_r;
  logic [31:0]             addr_s;
  logic [31:0]             caps_s;
  logic [31:0]             byte_mask_s;
  logic [31:0]             scratch_next_s;
  logic [31:0]             user_word_s;
  logic [31:0]             rd_data_s;
  logic                    rd_lo_s;
  logic                    wr_scratch_s;
  logic [READ_LATENCY-1:0] valid_pipe_r;
  logic [31:0]             data_pipe_r [READ_LATENCY];

  assign addr_s         = 32'(bus.address);
  assign caps_s         = {8'h01, 8'(NUM_USER_WORDS), 8'(UPTIME_W), 8'(READ_LATENCY)};
  assign rd_lo_s        = bus.read && (addr_s == 32'd3);
  assign wr_scratch_s   = bus.write && (addr_s == 32'd2);
  assign byte_mask_s    = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                           {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};
  assign scratch_next_s = (scratch_r & ~byte_mask_s) | (bus.writedata & byte_mask_s);

  // User constant lookup; addresses outside 6..5+NUM_USER_WORDS fall through as zero
  always_comb begin
    user_word_s = 32'h0;
    for (int k = 0; k < NUM_USER_WORDS; k++) begin
      user_word_s = user_word_s | ((addr_s == 32'(6 + k)) ? USER_WORDS[32*k +: 32] : 32'h0);
    end
  end

  // Register map read mux, evaluated in the accept cycle
  always_comb begin
    rd_data_s = 32'h0;
    case (addr_s)
      32'd0:   rd_data_s = SYSTEM_ID;
      32'd1:   rd_data_s = TIMESTAMP;
      32'd2:   rd_data_s = scratch_r;
      32'd3:   rd_data_s = uptime_r[31:0];
      32'd4:   rd_data_s = hi_snap_r;
      32'd5:   rd_data_s = caps_s;
      default: rd_data_s = user_word_s;
    endcase
  end

  // Uptime counter, scratch register and upper-half snapshot taken with each LO read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime_r  <= {UPTIME_W{1'b0}};
      scratch_r <= SCRATCH_RESET;
      hi_snap_r <= 32'h0;
    end else begin
      uptime_r <= uptime_r + UPTIME_W'(1);
      if (rd_lo_s) begin
        hi_snap_r <= 32'(uptime_r[UPTIME_W-1:32]);
      end
      if (wr_scratch_s) begin
        scratch_r <= scratch_next_s;
      end
    end
  end

  // Read pipeline; data stages load only with a valid token so readdata holds between pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_pipe_r <= {READ_LATENCY{1'b0}};
      for (int k = 0; k < READ_LATENCY; k++) begin
        data_pipe_r[k] <= 32'h0;
      end
    end else begin
      valid_pipe_r[0] <= bus.read;
      if (bus.read) begin
        data_pipe_r[0] <= rd_data_s;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        valid_pipe_r[k] <= valid_pipe_r[k-1];
        if (valid_pipe_r[k-1]) begin
          data_pipe_r[k] <= data_pipe_r[k-1];
        end
      end
    end
  end

  assign bus.readdata      = data_pipe_r[READ_LATENCY-1];
  assign bus.readdatavalid = valid_pipe_r[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_ext_slave.sv
// Randomized self-checking bench: two sysid_ext_slave configurations driven by one
// bus stimulus, checked every cycle against a register-map-level reference model.
module tb_sysid_ext_slave;

  localparam logic [31:0]  ID1   = 32'h2222_3333;
  localparam logic [31:0]  SCR1  = 32'h5A5A_0F0F;
  localparam logic [63:0]  USER0 = {32'hCAFE_0001, 32'hCAFE_0000};
  localparam logic [255:0] USER1 = {32'hA500_0007, 32'hA500_0006, 32'hA500_0005, 32'hA500_0004,
                                    32'hA500_0003, 32'hA500_0002, 32'hA500_0001, 32'hA500_0000};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sysid_ext_slave_if #(.ADDR_W(4)) bus0 ();
  sysid_ext_slave_if #(.ADDR_W(4)) bus1 ();

  logic [3:0]  s_addr = 4'h0;
  logic        s_rd   = 1'b0;
  logic        s_wr   = 1'b0;
  logic [31:0] s_wd   = 32'h0;
  logic [3:0]  s_be   = 4'h0;

  assign bus0.address = s_addr;  assign bus1.address = s_addr;
  assign bus0.read    = s_rd;    assign bus1.read    = s_rd;
  assign bus0.write   = s_wr;    assign bus1.write   = s_wr;
  assign bus0.writedata  = s_wd; assign bus1.writedata  = s_wd;
  assign bus0.byteenable = s_be; assign bus1.byteenable = s_be;

  sysid_ext_slave #(.ADDR_W(4), .NUM_USER_WORDS(2), .USER_WORDS(USER0),
                    .UPTIME_W(48), .READ_LATENCY(2))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));

  sysid_ext_slave #(.SYSTEM_ID(ID1), .SCRATCH_RESET(SCR1), .ADDR_W(4), .NUM_USER_WORDS(8),
                    .USER_WORDS(USER1), .UPTIME_W(33), .READ_LATENCY(3))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  longint unsigned up_m [2];
  logic [31:0]     scr_m [2];
  logic [31:0]     snap_m [2];
  logic [31:0]     last_m [2];
  int              cyc = 0;
  int              checks = 0;
  int              failures = 0;

  longint unsigned frc_val [2];
  int              frc_seq = 0;
  int              frc_seen = 0;
  logic            done = 1'b0;
  logic            done_seen = 1'b0;

  int          lit_cyc [512];
  int          lit_d   [512];
  logic        lit_vld [512];
  logic [31:0] lit_val [512];
  int          n_lit = 0;
  int          lit_rd = 0;

  logic        exp_v;
  logic        act_v;
  logic [31:0] act_d;

  function automatic int rl(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic longint unsigned up_mask(int d);
    return (d == 0) ? ((64'h1 << 48) - 64'h1) : ((64'h1 << 33) - 64'h1);
  endfunction

  // What a read of address a returns right now, straight from the register map
  function automatic logic [31:0] model_data(int d, int a);
    int nuw;
    nuw = (d == 0) ? 2 : 8;
    case (a)
      0:       return (d == 0) ? 32'h1111_1111 : ID1;
      1:       return 32'h52FE_6E76;
      2:       return scr_m[d];
      3:       return up_m[d][31:0];
      4:       return snap_m[d];
      5:       return (d == 0) ? {8'h01, 8'd2, 8'd48, 8'd2} : {8'h01, 8'd8, 8'd33, 8'd3};
      default: begin
        if (a >= 6 && a < 6 + nuw) return (d == 0) ? USER0[32*(a-6) +: 32] : USER1[32*(a-6) +: 32];
        return 32'h0;
      end
    endcase
  endfunction

  function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
    end
  endfunction

  // Reference model update on each edge, then per-cycle comparison just after it
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (frc_seq != frc_seen) begin
      up_m[0] = frc_val[0];
      up_m[1] = frc_val[1];
      frc_seen = frc_seq;
    end
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        up_m[d] = 64'h0;
        scr_m[d] = (d == 0) ? 32'h0 : SCR1;
        snap_m[d] = 32'h0;
        last_m[d] = 32'h0;
      end else begin
        if (s_rd) begin
          if (d == 0) q0.push_back('{cyc + rl(d) - 1, model_data(d, int'(s_addr))});
          else        q1.push_back('{cyc + rl(d) - 1, model_data(d, int'(s_addr))});
        end
        if (s_rd && s_addr == 4'd3) snap_m[d] = 32'(up_m[d] >> 32);
        if (s_wr && s_addr == 4'd2) begin
          for (int b = 0; b < 4; b++) begin
            if (s_be[b]) scr_m[d][8*b +: 8] = s_wd[8*b +: 8];
          end
        end
        up_m[d] = (up_m[d] + 64'h1) & up_mask(d);
      end
    end
    if (reset) begin
      q0.delete();
      q1.delete();
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_v = 1'b0;
      if (d == 0) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
          exp_v = 1'b1; last_m[0] = q0[0].data; void'(q0.pop_front());
        end
      end else begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
          exp_v = 1'b1; last_m[1] = q1[0].data; void'(q1.pop_front());
        end
      end
      act_v = (d == 0) ? bus0.readdatavalid : bus1.readdatavalid;
      act_d = (d == 0) ? bus0.readdata : bus1.readdata;
      chk("readdatavalid", d, 32'(act_v), 32'(exp_v));
      chk("readdata", d, act_d, last_m[d]);
    end
    while (lit_rd < n_lit && lit_cyc[lit_rd] <= cyc) begin
      act_v = (lit_d[lit_rd] == 0) ? bus0.readdatavalid : bus1.readdatavalid;
      act_d = (lit_d[lit_rd] == 0) ? bus0.readdata : bus1.readdata;
      chk("lit_valid", lit_d[lit_rd], 32'(act_v), 32'(lit_vld[lit_rd]));
      chk("lit_data", lit_d[lit_rd], act_d, lit_val[lit_rd]);
      lit_rd++;
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      chk("lits_consumed", 0, 32'(lit_rd), 32'(n_lit));
    end
  end

  task automatic lit(input int d, input int c, input logic v, input logic [31:0] val);
    lit_d[n_lit] = d; lit_cyc[n_lit] = c; lit_vld[n_lit] = v; lit_val[n_lit] = val;
    n_lit++;
  endtask

  // One bus cycle; when reading, pin both configurations to hand-computed results
  task automatic acc(input logic [3:0] a, input logic r, input logic w, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] e0, input logic [31:0] e1);
    if (r) begin
      lit(0, cyc + 2, 1'b1, e0);
      lit(1, cyc + 3, 1'b1, e1);
    end
    s_addr = a; s_rd = r; s_wr = w; s_wd = wd; s_be = be;
    @(negedge clock);
    s_rd = 1'b0; s_wr = 1'b0;
  endtask

  task automatic read_lit(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
    acc(a, 1'b1, 1'b0, 32'h0, 4'h0, e0, e1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    lit(0, cyc + 1, 1'b0, 32'h0);
    lit(1, cyc + 1, 1'b0, 32'h0);

    read_lit(4'd0, 32'h1111_1111, ID1);
    read_lit(4'd1, 32'h52FE_6E76, 32'h52FE_6E76);
    read_lit(4'd5, 32'h0102_3002, 32'h0108_2103);
    lit(0, cyc + 2, 1'b0, 32'h0102_3002);
    repeat (4) @(negedge clock);

    acc(4'd2, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0101, 32'h0, 32'h0);
    read_lit(4'd2, 32'h00AD_00EF, 32'h5AAD_0FEF);
    acc(4'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'h00AD_00EF, 32'h5AAD_0FEF);
    read_lit(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_lit(4'd4, 32'h0, 32'h0);

    acc(4'd0, 1'b0, 1'b1, 32'h0BAD_0BAD, 4'b1111, 32'h0, 32'h0);
    read_lit(4'd0, 32'h1111_1111, ID1);
    read_lit(4'd6, 32'hCAFE_0000, 32'hA500_0000);
    read_lit(4'd7, 32'hCAFE_0001, 32'hA500_0001);
    for (int a = 8; a < 16; a++) begin
      read_lit(4'(a), 32'h0, (a <= 13) ? (32'hA500_0000 + 32'(a - 6)) : 32'h0);
    end
    repeat (4) @(negedge clock);

    // Coherent snapshot across the 32-bit carry, and the 33-bit wrap
    force dut0.uptime_r = 48'h0000_FFFF_FFFF;
    force dut1.uptime_r = 33'h1_FFFF_FFFE;
    release dut0.uptime_r;
    release dut1.uptime_r;
    frc_val[0] = 64'h0000_0000_FFFF_FFFF;
    frc_val[1] = 64'h0000_0001_FFFF_FFFE;
    frc_seq++;
    read_lit(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    read_lit(4'd4, 32'h0, 32'h1);
    repeat (2) @(negedge clock);
    read_lit(4'd3, 32'h3, 32'h2);
    read_lit(4'd4, 32'h1, 32'h0);
    repeat (4) @(negedge clock);

    // Reset while reads are in flight: no pulse may emerge
    lit(0, cyc + 2, 1'b0, 32'h0);
    lit(1, cyc + 3, 1'b0, 32'h0);
    s_addr = 4'd0; s_rd = 1'b1;
    @(negedge clock);
    s_rd = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    read_lit(4'd2, 32'h0, SCR1);
    repeat (4) @(negedge clock);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        s_rd = 1'b0; s_wr = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
      end else begin
        s_addr = 4'($urandom_range(0, 15));
        s_rd   = ($urandom_range(0, 2) != 0);
        s_wr   = ($urandom_range(0, 3) == 0);
        s_wd   = $urandom;
        s_be   = 4'($urandom_range(0, 15));
        @(negedge clock);
      end
    end
    s_rd = 1'b0; s_wr = 1'b0;
    repeat (6) @(negedge clock);
    done = 1'b1;
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysid_ext_slave.md
Name: sysid_ext_slave

Overview:
- Parametrised Avalon-MM system-identification slave for the CPU subsystem.
- Read-only ID and build timestamp, plus:
  - an R/W scratch register;
  - a free-running uptime counter with atomic 64-bit snapshot;
  - a capability word;
  - up to 8 user constant words.
- Pipelined fixed read latency with readdatavalid, so the host interconnect can issue back-to-back reads.

Parameters:
- SYSTEM_ID, 32'h11111111: value of the ID register.
- TIMESTAMP, 32'h52FE6E76: build timestamp register value.
- SCRATCH_RESET, 32'h00000000: reset value of the scratch register.
- ADDR_W, 4: word-address width.
- NUM_USER_WORDS, 2: user constant words, range 0..8. Must satisfy 6+NUM_USER_WORDS <= 2**ADDR_W; elaboration error otherwise.
- USER_WORDS, {NUM_USER_WORDS{32'h0}}: packed constants; word k = bits [32k+31:32k].
- UPTIME_W, 48: uptime counter width, range 33..64.
- READ_LATENCY, 1: cycles from accepted read to readdatavalid, range 1..3.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- address  in  ADDR_W  word address
- read  in  1  read strobe; accepted every cycle it is high
- write  in  1  write strobe; accepted every cycle it is high
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- readdata  out  32  read data, valid when readdatavalid=1
- readdatavalid  out  1  one-cycle pulse per accepted read

Behaviour:
- Reset (async assert, sync-safe deassert on clock): uptime=0, scratch=SCRATCH_RESET, hi_snap=0, all pipeline stages invalid, readdata=0, readdatavalid=0.
- No waitrequest. Every read or write strobe is accepted in the cycle it is high.
- Register map (word address):
  - 0 ID, RO = SYSTEM_ID.
  - 1 TIMESTAMP, RO.
  - 2 SCRATCH, RW; per-byte write under byteenable.
  - 3 UPTIME_LO, RO = uptime[31:0].
  - 4 UPTIME_HI, RO = hi_snap, zero-extended uptime[UPTIME_W-1:32] captured at the last UPTIME_LO read.
  - 5 CAPS, RO = {8'h01 version, 8'(NUM_USER_WORDS), 8'(UPTIME_W), 8'(READ_LATENCY)}.
  - 6..5+NUM_USER_WORDS USER[k], RO.
  - All other addresses read 0.
- Writes to RO or unmapped addresses are ignored without error.
- Uptime counter:
  - Increments by 1 every clock; wraps from 2**UPTIME_W-1 to 0.
  - Value sampled by a read is the counter value in the accept cycle.
  - UPTIME_LO read in cycle t loads hi_snap with the upper bits from the same cycle t. Hi/lo form one coherent sample even across a carry.
  - UPTIME_HI read without a prior LO read returns the previous snapshot; 0 after reset.
- Read pipeline:
  - Data is selected in the accept cycle.
  - Data and valid travel through READ_LATENCY register stages.
  - readdatavalid is high exactly READ_LATENCY cycles after the accept.
  - Back-to-back reads give consecutive valid pulses in order.
  - readdata holds its last value when readdatavalid=0.
- Simultaneous read and write to SCRATCH in the same cycle: the read returns the pre-write value; the write takes effect next cycle.
- Reset mid-read discards all in-flight reads. No readdatavalid is produced after reset deasserts for reads accepted before reset.

Test Plan:
- Reset, then read addr 0,1,5 back-to-back with READ_LATENCY=2 -> readdatavalid on cycles 2,3,4 with data 32'h11111111, 32'h52FE6E76, 32'h01023002.
- Write scratch 32'hDEADBEEF with byteenable=4'b0101 after reset -> readback 32'h00AD00EF. Same-cycle read+write of 32'hFFFFFFFF returns 32'h00AD00EF; next read returns 32'hFFFFFFFF.
- Force uptime to 48'h0000_FFFF_FFFF, read LO then HI -> LO=32'hFFFFFFFF, HI=32'h00000000 (coherent snapshot). Read LO again later -> HI then reads 32'h00000001.
- UPTIME_W=33, run past 2**33-1 -> counter wraps to 0; HI snapshot is 0 or 1 only, upper bits 0.
- NUM_USER_WORDS=2, USER_WORDS={32'hCAFE0001,32'hCAFE0000} -> addr 6 reads 32'hCAFE0000, addr 7 reads 32'hCAFE0001, addr 8..15 read 0. Writes to addr 0 leave ID unchanged.
- Assert reset one cycle after a read is accepted with READ_LATENCY=3 -> no readdatavalid pulse. Outputs 0; scratch returns to SCRATCH_RESET.
